// File: rtl/macc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : macc_seq_ctrl
// Purpose  : Per-PE MAC sequencer. Accepts a stream of signed 8-bit operand
//            pairs, feeds them back-to-back into the external pipelined Booth
//            multiplier (Mul), follows the in-flight products with a tag pipe
//            and accumulates one signed dot product per burst. The result is
//            returned over a valid/ready handshake.
// Ports    : clk, rst_n                   clock / async active-low reset
//            in_valid, in_ready           operand handshake
//            in_x, in_y, in_last          signed operands, end-of-burst flag
//            mul_x, mul_y                 registered operands to Mul
//            mul_p                        signed product from Mul (15 bits)
//            out_valid, out_ready         result handshake
//            out_acc, out_cnt, out_ovf    sum, term count, sticky overflow
//            busy                         controller not idle
// Revision : 1.0 - initial release
// ============================================================================
module macc_seq_ctrl #(
    parameter int MUL_LAT = 8,
    parameter int ACC_W   = 24,
    parameter int CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_x,
    input  logic [7:0]       in_y,
    input  logic             in_last,
    output logic [7:0]       mul_x,
    output logic [7:0]       mul_y,
    input  logic [14:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [MUL_LAT:0]   r_tag;
    logic [7:0]         r_mul_x;
    logic [7:0]         r_mul_y;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    logic               w_accept;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_last;
    logic               w_drain_done;
    logic [ACC_W-1:0]   w_p_ext;
    logic [ACC_W-1:0]   w_sum;
    logic               w_ovf_step;

    // in_ready is gated by rst_n so every output reads 0 while reset is held.
    assign in_ready  = rst_n & ((r_state == ST_IDLE) | (r_state == ST_RUN));
    assign w_accept  = in_valid & in_ready;

    // Count this accept would produce; the first pair of a burst counts as 1.
    assign w_cnt_inc = (r_state == ST_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);

    // A full counter forces the burst closed so the count can never wrap.
    assign w_last    = in_last | (w_cnt_inc == c_cnt_max);

    // The product leaving the pipe is the last one when nothing trails it.
    assign w_drain_done = r_tag[MUL_LAT] & ~(|r_tag[MUL_LAT-1:0]);

    assign w_p_ext   = {{(ACC_W-15){mul_p[14]}}, mul_p};
    assign w_sum     = r_acc + w_p_ext;
    assign w_ovf_step = (r_acc[ACC_W-1] == w_p_ext[ACC_W-1]) &&
                        (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)            w_state_nxt = w_last ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (w_accept && w_last)  w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drain_done)        w_state_nxt = ST_DONE;
            ST_DONE:  if (out_ready)           w_state_nxt = ST_IDLE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_tag   <= '0;
            r_mul_x <= 8'h00;
            r_mul_y <= 8'h00;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tag   <= {r_tag[MUL_LAT-1:0], w_accept};
            // Idle slots feed zeros so Mul toggles as little as possible.
            r_mul_x <= w_accept ? in_x : 8'h00;
            r_mul_y <= w_accept ? in_y : 8'h00;
            if (w_accept) begin
                r_cnt <= w_cnt_inc;
            end
            // No product can be in flight when a burst starts from IDLE.
            if (w_accept && (r_state == ST_IDLE)) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (r_tag[MUL_LAT]) begin
                r_acc <= w_sum;
                r_ovf <= r_ovf | w_ovf_step;
            end
        end
    end

    assign mul_x     = r_mul_x;
    assign mul_y     = r_mul_y;
    assign out_valid = (r_state == ST_DONE);
    assign out_acc   = r_acc;
    assign out_cnt   = r_cnt;
    assign out_ovf   = r_ovf;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_macc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_macc_seq_ctrl
// Purpose  : Bench for macc_seq_ctrl. Two instances share the stimulus: one
//            with a 24-bit accumulator, one with a 16-bit accumulator. A
//            simple delay-line stands in for the Booth multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_macc_seq_ctrl;

    localparam int ML = 8;
    localparam int CW = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  in_x = 8'h00;
    logic [7:0]  in_y = 8'h00;

    logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b;
    logic        out_ovf_a, out_ovf_b, busy_a, busy_b;
    logic [7:0]  mul_x_a, mul_y_a, mul_x_b, mul_y_b;
    logic [14:0] mul_p_a, mul_p_b;
    logic [23:0] out_acc_a;
    logic [15:0] out_acc_b;
    logic [CW-1:0] out_cnt_a, out_cnt_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int bx [1024];
    int by [1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    macc_seq_ctrl #(.MUL_LAT(ML), .ACC_W(24), .CNT_W(CW)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_x(in_x), .in_y(in_y), .in_last(in_last), .mul_x(mul_x_a), .mul_y(mul_y_a),
        .mul_p(mul_p_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_acc(out_acc_a), .out_cnt(out_cnt_a), .out_ovf(out_ovf_a), .busy(busy_a));

    macc_seq_ctrl #(.MUL_LAT(ML), .ACC_W(16), .CNT_W(CW)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_x(in_x), .in_y(in_y), .in_last(in_last), .mul_x(mul_x_b), .mul_y(mul_y_b),
        .mul_p(mul_p_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_acc(out_acc_b), .out_cnt(out_cnt_b), .out_ovf(out_ovf_b), .busy(busy_b));

    // Multiplier stand-in: product of the operands presented ML cycles earlier.
    logic [14:0] pa [ML];
    logic [14:0] pb [ML];
    initial for (int k = 0; k < ML; k++) begin pa[k] = '0; pb[k] = '0; end
    always @(posedge clk) begin
        pa[0] <= 15'($signed({{8{mul_x_a[7]}}, mul_x_a}) * $signed({{8{mul_y_a[7]}}, mul_y_a}));
        pb[0] <= 15'($signed({{8{mul_x_b[7]}}, mul_x_b}) * $signed({{8{mul_y_b[7]}}, mul_y_b}));
        for (int k = 1; k < ML; k++) begin
            pa[k] <= pa[k-1];
            pb[k] <= pb[k-1];
        end
    end
    assign mul_p_a = pa[ML-1];
    assign mul_p_b = pb[ML-1];

    // Reference: 15-bit product as Mul delivers it, summed with wrap at W bits.
    function automatic int prod15(input int x, input int y);
        int p;
        p = x * y;
        if (p > 16383) p -= 32768;
        return p;
    endfunction

    function automatic void model(input int n, input int w, output longint acc, output bit ovf);
        longint lim;
        lim = longint'(1) << (w - 1);
        acc = 0;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            acc += prod15(bx[i], by[i]);
            if (acc >= lim) begin acc -= 2 * lim; ovf = 1'b1; end
            else if (acc < -lim) begin acc += 2 * lim; ovf = 1'b1; end
        end
    endfunction

    function automatic int rnd8();
        logic [7:0] v;
        v = 8'($urandom);
        return int'($signed(v));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input bit last, output int acc_cyc);
        in_valid = 1'b1;
        in_x     = 8'(bx[idx]);
        in_y     = 8'(by[idx]);
        in_last  = last;
        acc_cyc  = cyc;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Waits (bounded) for out_valid; reports whether in_ready stayed low.
    task automatic wait_valid(output bit ok, output int vcyc, output bit rdy_low);
        ok = 1'b0;
        vcyc = -1;
        rdy_low = 1'b1;
        for (int i = 0; i < ML + 8; i++) begin
            if (in_ready_a || in_ready_b) rdy_low = 1'b0;
            if (out_valid_a) begin
                ok = 1'b1;
                vcyc = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic run_burst(input int n, input int gap, input bit no_last,
                             output int first, output int last,
                             output bit ok, output int vcyc, output bit rdy_low);
        int c;
        for (int i = 0; i < n; i++) begin
            send(i, !no_last && (i == n - 1), c);
            if (i == 0) first = c;
            last = c;
            if (i < n - 1) repeat ((gap < 0) ? $urandom_range(0, 2) : gap) tick();
        end
        wait_valid(ok, vcyc, rdy_low);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({in_ready_a, busy_a, out_valid_a, out_ovf_a, mul_x_a, mul_y_a, out_cnt_a, out_acc_a} !== '0)
            begin errors++; $display("FAIL reset_a: outputs=%h required 0",
                {in_ready_a, busy_a, out_valid_a, out_ovf_a, mul_x_a, mul_y_a, out_cnt_a, out_acc_a}); end
        checks++;
        if ({in_ready_b, busy_b, out_valid_b, out_ovf_b, mul_x_b, mul_y_b, out_cnt_b, out_acc_b} !== '0)
            begin errors++; $display("FAIL reset_b: outputs=%h required 0",
                {in_ready_b, busy_b, out_valid_b, out_ovf_b, mul_x_b, mul_y_b, out_cnt_b, out_acc_b}); end
        @(negedge clk) rst_n = 1'b1;
        tick();
        checks++;
        if ({in_ready_a, busy_a} !== 2'b10)
            begin errors++; $display("FAIL idle_after_reset: ready,busy=%b required 10", {in_ready_a, busy_a}); end
    endtask

    task automatic test_basic();
        int f, l, v; bit ok, rl; longint ea, eb; bit oa, ob;
        bx[0] = 1; by[0] = 1; bx[1] = 2; by[1] = 2; bx[2] = 8; by[2] = 3; bx[3] = 15; by[3] = 15;
        model(4, 24, ea, oa);
        model(4, 16, eb, ob);
        run_burst(4, 0, 1'b0, f, l, ok, v, rl);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: out_valid never rose"); end
        checks++; if (v !== f + ML + 5) begin errors++; $display("FAIL basic_latency: cycle %0d required %0d", v, f + ML + 5); end
        checks++; if (longint'($signed(out_acc_a)) !== 254) begin errors++; $display("FAIL basic_acc: %0d required 254", $signed(out_acc_a)); end
        checks++; if (longint'($signed(out_acc_b)) !== eb) begin errors++; $display("FAIL basic_acc16: %0d required %0d", $signed(out_acc_b), eb); end
        checks++; if (out_cnt_a !== CW'(4) || out_ovf_a !== oa) begin errors++; $display("FAIL basic_cnt_ovf: cnt=%0d ovf=%b required 4 %b", out_cnt_a, out_ovf_a, oa); end
        checks++; if (!rl) begin errors++; $display("FAIL basic_ready: in_ready=1 during drain, required 0"); end
        tick();
    endtask

    task automatic test_single();
        int f, l, v; bit ok, rl;
        bx[0] = -86; by[0] = 85;
        run_burst(1, 0, 1'b0, f, l, ok, v, rl);
        checks++; if (!ok || v !== f + ML + 2) begin errors++; $display("FAIL single_latency: cycle %0d required %0d", v, f + ML + 2); end
        checks++; if (longint'($signed(out_acc_a)) !== -7310) begin errors++; $display("FAIL single_acc: %0d required -7310", $signed(out_acc_a)); end
        checks++; if (out_cnt_a !== CW'(1)) begin errors++; $display("FAIL single_cnt: %0d required 1", out_cnt_a); end
        checks++; if (!rl) begin errors++; $display("FAIL single_ready: in_ready=1 in a+1..a+%0d, required 0", ML + 2); end
        tick();
    endtask

    task automatic test_gaps();
        int f, l, v; bit ok, rl;
        bx[0] = 127; by[0] = 127; bx[1] = -1; by[1] = -1; bx[2] = -31; by[2] = 4;
        run_burst(3, 2, 1'b0, f, l, ok, v, rl);
        checks++; if (!ok || v !== l + ML + 2) begin errors++; $display("FAIL gaps_latency: cycle %0d required %0d", v, l + ML + 2); end
        checks++; if (longint'($signed(out_acc_a)) !== 16006) begin errors++; $display("FAIL gaps_acc: %0d required 16006", $signed(out_acc_a)); end
        checks++; if (out_cnt_a !== CW'(3)) begin errors++; $display("FAIL gaps_cnt: %0d required 3", out_cnt_a); end
        tick();
    endtask

    task automatic test_backpressure();
        int f, l, v, a; bit ok, rl, held;
        bx[0] = 1; by[0] = 1; bx[1] = 2; by[1] = 2; bx[2] = 8; by[2] = 3; bx[3] = 15; by[3] = 15;
        out_ready = 1'b0;
        run_burst(4, 0, 1'b0, f, l, ok, v, rl);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: out_valid never rose"); end
        in_valid = 1'b1; in_x = 8'd5; in_y = 8'd5; in_last = 1'b1;
        held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid_a !== 1'b1 || $signed(out_acc_a) !== 254 || out_cnt_a !== CW'(4) || in_ready_a !== 1'b0) held = 1'b0;
        end
        checks++; if (!held) begin errors++; $display("FAIL bp_hold: valid=%b acc=%0d ready=%b required 1 254 0", out_valid_a, $signed(out_acc_a), in_ready_a); end
        out_ready = 1'b1;
        tick();
        checks++; if ({out_valid_a, in_ready_a, busy_a} !== 3'b010) begin errors++; $display("FAIL bp_release: valid,ready,busy=%b required 010", {out_valid_a, in_ready_a, busy_a}); end
        a = cyc;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        wait_valid(ok, v, rl);
        checks++; if (!ok || v !== a + ML + 2) begin errors++; $display("FAIL bp_next_latency: cycle %0d required %0d", v, a + ML + 2); end
        checks++; if ($signed(out_acc_a) !== 25 || out_cnt_a !== CW'(1)) begin errors++; $display("FAIL bp_next_acc: acc=%0d cnt=%0d required 25 1", $signed(out_acc_a), out_cnt_a); end
        tick();
    endtask

    task automatic test_wrap();
        int f, l, v; bit ok, rl;
        for (int i = 0; i < 4; i++) begin bx[i] = 127; by[i] = 127; end
        run_burst(4, 0, 1'b0, f, l, ok, v, rl);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: out_valid never rose"); end
        checks++; if ($signed(out_acc_b) !== -1020 || out_ovf_b !== 1'b1) begin errors++; $display("FAIL wrap16: acc=%0d ovf=%b required -1020 1", $signed(out_acc_b), out_ovf_b); end
        checks++; if ($signed(out_acc_a) !== 64516 || out_ovf_a !== 1'b0) begin errors++; $display("FAIL wrap24: acc=%0d ovf=%b required 64516 0", $signed(out_acc_a), out_ovf_a); end
        tick();
        bx[0] = 1; by[0] = 1;
        run_burst(1, 0, 1'b0, f, l, ok, v, rl);
        checks++; if ($signed(out_acc_b) !== 1 || out_ovf_b !== 1'b0) begin errors++; $display("FAIL wrap_clear: acc=%0d ovf=%b required 1 0", $signed(out_acc_b), out_ovf_b); end
        tick();
    endtask

    task automatic test_reset_mid();
        int c, f, l, v; bit ok, rl, quiet;
        for (int i = 0; i < 3; i++) begin bx[i] = rnd8(); by[i] = rnd8(); send(i, 1'b0, c); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready_a, busy_a, out_valid_a, out_ovf_a, mul_x_a, mul_y_a, out_cnt_a, out_acc_a} !== '0)
            begin errors++; $display("FAIL midreset_zero: outputs=%h required 0",
                {in_ready_a, busy_a, out_valid_a, out_ovf_a, mul_x_a, mul_y_a, out_cnt_a, out_acc_a}); end
        @(negedge clk) rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < ML + 6; i++) begin tick(); if (out_valid_a || busy_a) quiet = 1'b0; end
        checks++; if (!quiet) begin errors++; $display("FAIL midreset_quiet: activity after reset, required none"); end
        bx[0] = 3; by[0] = 3;
        run_burst(1, 0, 1'b0, f, l, ok, v, rl);
        checks++; if (!ok || $signed(out_acc_a) !== 9 || out_cnt_a !== CW'(1)) begin errors++; $display("FAIL midreset_next: acc=%0d cnt=%0d required 9 1", $signed(out_acc_a), out_cnt_a); end
        tick();
    endtask

    task automatic test_random();
        int f, l, v, n; bit ok, rl; longint ea, eb; bit oa, ob;
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin bx[i] = rnd8(); by[i] = rnd8(); end
            if (t == 0) begin bx[0] = -128; by[0] = -128; end
            model(n, 24, ea, oa);
            model(n, 16, eb, ob);
            run_burst(n, -1, 1'b0, f, l, ok, v, rl);
            checks++; if (!ok || v !== l + ML + 2) begin errors++; $display("FAIL rand%0d_latency: cycle %0d required %0d", t, v, l + ML + 2); end
            checks++; if (longint'($signed(out_acc_a)) !== ea || out_ovf_a !== oa) begin errors++; $display("FAIL rand%0d_acc24: %0d/%b required %0d/%b", t, $signed(out_acc_a), out_ovf_a, ea, oa); end
            checks++; if (longint'($signed(out_acc_b)) !== eb || out_ovf_b !== ob) begin errors++; $display("FAIL rand%0d_acc16: %0d/%b required %0d/%b", t, $signed(out_acc_b), out_ovf_b, eb, ob); end
            checks++; if (out_cnt_a !== CW'(n)) begin errors++; $display("FAIL rand%0d_cnt: %0d required %0d", t, out_cnt_a, n); end
            if ($urandom_range(0, 1) == 1) begin
                out_ready = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                out_ready = 1'b1;
            end
            tick();
        end
    endtask

    task automatic test_forced_last();
        int f, l, v, n; bit ok, rl; longint ea, eb; bit oa, ob;
        n = (1 << CW) - 1;
        for (int i = 0; i < n; i++) begin bx[i] = rnd8(); by[i] = (bx[i] < 0) ? -128 : 127; end
        model(n, 24, ea, oa);
        model(n, 16, eb, ob);
        run_burst(n, 0, 1'b1, f, l, ok, v, rl);
        checks++; if (!ok || v !== f + n + ML + 1) begin errors++; $display("FAIL forced_latency: cycle %0d required %0d", v, f + n + ML + 1); end
        checks++; if (!rl) begin errors++; $display("FAIL forced_ready: in_ready=1 after forced last, required 0"); end
        checks++; if (out_cnt_a !== CW'(n)) begin errors++; $display("FAIL forced_cnt: %0d required %0d", out_cnt_a, n); end
        checks++; if (longint'($signed(out_acc_a)) !== ea || out_ovf_a !== oa) begin errors++; $display("FAIL forced_acc24: %0d/%b required %0d/%b", $signed(out_acc_a), out_ovf_a, ea, oa); end
        checks++; if (longint'($signed(out_acc_b)) !== eb || out_ovf_b !== ob) begin errors++; $display("FAIL forced_acc16: %0d/%b required %0d/%b", $signed(out_acc_b), out_ovf_b, eb, ob); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_gaps();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        test_forced_last();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
